sb_mem_responder: RTL

SB_MEM_RESPONDER -- requirements
Module: sb_mem_responder

---
 rtl/sb_mem_responder_if.sv | 41 ++++
 rtl/sb_mem_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sb_mem_responder_if.sv
// ---------------------------------------------------------------------------
// sb_mem_responder_if -- shared-bus signal bundle between one bus master and
// the sb_mem_responder memory slave.
//
//   req      master -> slave   bus request
//   gnt      slave  -> master  bus grant
//   addr     master -> slave   8-bit transfer address, sampled with start
//   mode     master -> slave   2'b00 read, 2'b01 write, 2'b1x illegal
//   start    master -> slave   one-cycle transfer strobe
//   wdata    master -> slave   write data, sampled with start
//   rdata    slave  -> master  read data
//   rdata_oe slave  -> master  drive enable for the shared data bus
//   rdy      slave  -> master  one-cycle transfer-complete pulse
//   abort    master -> slave   cancels an in-flight transfer
//   avail    slave  -> master  1 = no transfer in flight
//   err      slave  -> master  one-cycle rejected-transfer pulse
// ---------------------------------------------------------------------------
interface sb_mem_responder_if;
   logic       req;
   logic       gnt;
   logic [7:0] addr;
   logic [1:0] mode;
   logic       start;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rdata_oe;
   logic       rdy;
   logic       abort;
   logic       avail;
   logic       err;

   modport master (
      output req, addr, mode, start, wdata, abort,
      input  gnt, rdata, rdata_oe, rdy, avail, err
   );

   modport slave (
      input  req, addr, mode, start, wdata, abort,
      output gnt, rdata, rdata_oe, rdy, avail, err
   );
endinterface

// File: rtl/sb_mem_responder.sv
// ---------------------------------------------------------------------------
// sb_mem_responder -- 256 x 8 memory slave on a request/grant shared bus.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  sb_mem_responder_if.slave (req/gnt handshake, addr/mode/start/wdata
//        transfer request, rdata/rdata_oe/rdy response, abort, avail, err)
//
// Parameters:
//   MINADDR, MAXADDR  inclusive address window served by this responder
//   WAIT_CYCLES       BUSY duration in cycles, 1..15
//
// Optional feature: define SB_MEM_RESPONDER_ERR_EN to pulse err for one
// cycle after a start that is rejected in GRANT (bad address or mode).
// Without it err is tied low and rejected starts are silently dropped.
// ---------------------------------------------------------------------------
module sb_mem_responder #(
   parameter int MINADDR     = 0,
   parameter int MAXADDR     = 255,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   sb_mem_responder_if.slave   bus
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic [1:0] M_READ   = 2'b00;
   localparam logic [1:0] M_WRITE  = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q;
   logic [7:0] addr_q;
   logic [1:0] mode_q;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;
   logic [7:0] mem_q [256];

   logic in_win, start_ok, accept, busy_last, commit, rd_load;

   // Signed int comparison keeps the window test clean for any parameter
   // values, including the degenerate full 0..255 window.
   assign in_win    = (int'(bus.addr) >= MINADDR) && (int'(bus.addr) <= MAXADDR);
   assign start_ok  = bus.start && !bus.mode[1] && in_win;
   assign accept    = (state_q == S_GRANT) && start_ok;
   // Final BUSY cycle that actually completes; abort in this cycle wins.
   assign busy_last = (state_q == S_BUSY) && (cnt_q == 4'd0) && !bus.abort;
   assign commit    = busy_last && (mode_q == M_WRITE);
   assign rd_load   = busy_last && (mode_q == M_READ);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req) state_d = S_GRANT;
         S_GRANT: begin
            if (accept)                      state_d = S_BUSY;
            else if (!bus.req && !bus.start) state_d = S_IDLE;
         end
         S_BUSY: begin
            if (bus.abort)           state_d = S_IDLE;
            else if (cnt_q == 4'd0)  state_d = S_DONE;
         end
         S_DONE:  state_d = bus.req ? S_GRANT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.gnt      = (state_q != S_IDLE);
      bus.rdy      = (state_q == S_DONE);
      bus.rdata_oe = (state_q == S_DONE) && (mode_q == M_READ);
      bus.avail    = (state_q != S_BUSY);
      bus.rdata    = rdata_q;
   end

   // ---------------- transfer datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 4'd0;
         addr_q  <= 8'd0;
         mode_q  <= 2'b00;
         wdata_q <= 8'd0;
         rdata_q <= 8'd0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr;
            mode_q  <= bus.mode;
            wdata_q <= bus.wdata;
            cnt_q   <= CNT_LOAD;
         end else if ((state_q == S_BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         // rdata only changes on a completing read, so it holds otherwise.
         if (rd_load) rdata_q <= mem_q[addr_q];
      end
   end

   // Memory is deliberately not reset. A reset mid-transfer forces IDLE
   // asynchronously, so commit can never fire for a discarded transfer.
   always_ff @(posedge clk) begin
      if (commit) mem_q[addr_q] <= wdata_q;
   end

`ifdef SB_MEM_RESPONDER_ERR_EN
   logic reject, err_q;
   assign reject = (state_q == S_GRANT) && bus.start && !start_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= reject;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule
